// File: rtl/ay_multi_bus_ctrl_pkg.sv
// ay_pkg: shared definitions for the multi-chip AY/YM PSG bus controller.
//   ayState_t    - bus sequencer states
//   AY_PORT_LO   - low address bits of both PSG ports (#xxFD)
//   AY_ADDR_HI   - a[15:14] of the register-address port (#FFFD)
//   AY_DATA_HI   - a[15:14] of the data port (#BFFD)
//   TS_SEL_MASK  - d[7:3] pattern marking a TurboSound chip-select write
//   AY_MAX_CHIPS - upper bound on NUM_CHIPS
//   isPsgPort()  - qualifies an access as a PSG port cycle
package ay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_READ = 3'd3,
    ST_HOLD = 3'd4
  } ayState_t;

  localparam logic [2:0] AY_PORT_LO   = 3'b101;
  localparam logic [1:0] AY_ADDR_HI   = 2'b11;
  localparam logic [1:0] AY_DATA_HI   = 2'b10;
  localparam logic [4:0] TS_SEL_MASK  = 5'b11111;
  localparam int         AY_MAX_CHIPS = 8;

  // a[1]==0 is already implied by a[2:0]==3'b101. The access must be a plain
  // I/O cycle (not an interrupt acknowledge) with normal ROM paging active.
  function automatic logic isPsgPort(input logic [2:0] aLo, input logic m1,
                                     input logic dos, input logic iorq);
    return (aLo == AY_PORT_LO) && m1 && dos && !iorq;
  endfunction

endpackage

// File: rtl/ay_multi_bus_ctrl_reg_shadow.sv
// ay_reg_shadow: per-chip copy of the PSG register index latch and the 16
// register contents, so that reads can be answered without touching the bus.
// Ports:
//   i_cpu_clock - system clock (rising edge)
//   i_reset     - asynchronous reset, active-low
//   i_sel       - currently selected chip index
//   i_idxWe     - capture i_d[3:0] as the selected chip's register index
//   i_dataWe    - write i_d into the selected chip's indexed register
//   i_d         - sampled CPU data
//   o_q         - contents of the selected chip's indexed register
module ay_reg_shadow
  import ay_pkg::*;
#(
  parameter int NUM_CHIPS = 2
) (
  input  logic       i_cpu_clock,
  input  logic       i_reset,
  input  logic [2:0] i_sel,
  input  logic       i_idxWe,
  input  logic       i_dataWe,
  input  logic [7:0] i_d,
  output logic [7:0] o_q
);

  localparam int SEL_W = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;

  logic [SEL_W-1:0] w_sel;
  logic             w_unusedSel;
  logic [3:0]       r_idx  [NUM_CHIPS];
  logic [7:0]       r_regs [NUM_CHIPS][16];

  // The chip-select latch never holds an index >= NUM_CHIPS, so only the low
  // bits are needed to address the register file.
  assign w_sel       = i_sel[SEL_W-1:0];
  assign w_unusedSel = ^i_sel;

  // Index latch and register file, cleared together with the real chips.
  always_ff @(posedge i_cpu_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int c = 0; c < NUM_CHIPS; c++) begin
        r_idx[c] <= 4'd0;
        for (int r = 0; r < 16; r++) r_regs[c][r] <= 8'd0;
      end
    end else begin
      if (i_idxWe)  r_idx[w_sel] <= i_d[3:0];
      if (i_dataWe) r_regs[w_sel][r_idx[w_sel]] <= i_d;
    end
  end

  assign o_q = r_regs[w_sel][r_idx[w_sel]];

endmodule

// File: rtl/ay_multi_bus_ctrl.sv
// ay_multi_bus_ctrl: Z80-side decoder and bus sequencer for 1..8 AY/YM PSGs on
// one shared bus (TurboSound-style chip select via #FFFD writes of #F8..#FF).
// Optional feature macro: AY_REG_SHADOW_EN (register shadow + o_shadow_q).
// Ports:
//   i_cpu_clock                - Z80 clock, rising edge
//   i_reset                    - asynchronous reset, active-low
//   i_a, i_d                   - CPU address / data bus
//   i_iorq, i_rd, i_wr, i_m1   - Z80 strobes, active-low
//   i_dos                      - high = normal paging, low blocks PSG decode
//   o_bc1, o_bdir              - shared PSG control lines
//   o_ym_sel                   - one-hot chip enable, active-low
//   o_ioge_c                   - high while a decoded PSG access is handled
//   o_busy                     - sequencer not idle
//   o_overrun                  - sticky: access started while busy
//   o_shadow_q (macro only)    - shadow register value for #FFFD reads
module ay_multi_bus_ctrl
  import ay_pkg::*;
#(
  parameter int NUM_CHIPS    = 2,
  parameter int PULSE_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                 i_cpu_clock,
  input  logic                 i_reset,
  input  logic [15:0]          i_a,
  input  logic                 i_iorq,
  input  logic                 i_rd,
  input  logic                 i_wr,
  input  logic                 i_m1,
  input  logic                 i_dos,
  input  logic [7:0]           i_d,
  output logic                 o_bc1,
  output logic                 o_bdir,
  output logic [NUM_CHIPS-1:0] o_ym_sel,
  output logic                 o_ioge_c,
  output logic                 o_busy,
  output logic                 o_overrun
`ifdef AY_REG_SHADOW_EN
  ,output logic [7:0]          o_shadow_q
`endif
);

  if (NUM_CHIPS < 1 || NUM_CHIPS > AY_MAX_CHIPS) begin : gBadChips
    $error("NUM_CHIPS must be 1..8");
  end
  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 4 || HOLD_CYCLES < 0 || HOLD_CYCLES > 3) begin : gBadTiming
    $error("PULSE_CYCLES must be 1..4 and HOLD_CYCLES 0..3");
  end
  // A write must finish inside one Z80 I/O cycle: sample cycle + pulse + hold.
  if (1 + PULSE_CYCLES + HOLD_CYCLES > 4) begin : gBadOccupancy
    $error("1+PULSE_CYCLES+HOLD_CYCLES exceeds 4");
  end

  localparam logic [1:0] PULSE_LAST = 2'(PULSE_CYCLES - 1);
  localparam logic [1:0] HOLD_LAST  = (HOLD_CYCLES == 0) ? 2'd0 : 2'(HOLD_CYCLES - 1);

  logic [1:0] r_aHi;
  logic [2:0] r_aLo;
  logic [7:0] r_d;
  logic       r_iorq, r_rd, r_wr, r_m1, r_dos;
  logic       r_rdStbQ, r_wrStbQ;
  logic       w_unusedA;
  logic       w_rdStb, w_wrStb, w_port, w_isAddr, w_isData;
  logic       w_wrEdge, w_rdEdge, w_startAddr, w_startData, w_startRead;
  logic       w_start, w_accept, w_selWr, w_selValid, w_busy;
  logic [2:0] w_newIdx;
  ayState_t   r_state, w_next;
  logic [1:0] r_cnt;
  logic       w_bc1, w_bdir;
  logic [2:0] r_selIdx;
  logic       r_selPulse;

  assign w_unusedA = ^i_a[13:3];

  // Bus inputs are sampled once so the decoder only ever sees clean, clock-
  // aligned levels; the second strobe register gives the falling edge.
  always_ff @(posedge i_cpu_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_aHi    <= 2'd0;
      r_aLo    <= 3'd0;
      r_d      <= 8'd0;
      r_iorq   <= 1'b1;
      r_rd     <= 1'b1;
      r_wr     <= 1'b1;
      r_m1     <= 1'b1;
      r_dos    <= 1'b0;
      r_rdStbQ <= 1'b1;
      r_wrStbQ <= 1'b1;
    end else begin
      r_aHi    <= i_a[15:14];
      r_aLo    <= i_a[2:0];
      r_d      <= i_d;
      r_iorq   <= i_iorq;
      r_rd     <= i_rd;
      r_wr     <= i_wr;
      r_m1     <= i_m1;
      r_dos    <= i_dos;
      r_rdStbQ <= w_rdStb;
      r_wrStbQ <= w_wrStb;
    end
  end

  // Combined strobes are active-low: low only while both IORQ and RD/WR are.
  assign w_rdStb     = r_iorq | r_rd;
  assign w_wrStb     = r_iorq | r_wr;
  assign w_port      = isPsgPort(r_aLo, r_m1, r_dos, r_iorq);
  assign w_isAddr    = w_port && (r_aHi == AY_ADDR_HI);
  assign w_isData    = w_port && (r_aHi == AY_DATA_HI);
  assign w_wrEdge    = !w_wrStb && r_wrStbQ;
  // A read is ignored while WR is also low: the write wins.
  assign w_rdEdge    = !w_rdStb && r_rdStbQ && w_wrStb;
  assign w_startAddr = w_wrEdge && w_isAddr;
  assign w_startData = w_wrEdge && w_isData;
  assign w_startRead = w_rdEdge && w_isAddr;
  assign w_start     = w_startAddr || w_startData || w_startRead;
  assign w_accept    = w_start && (r_state == ST_IDLE);
  assign w_selWr     = (r_d[7:3] == TS_SEL_MASK);
  assign w_newIdx    = ~r_d[2:0];
  assign w_selValid  = ({1'b0, w_newIdx} < 4'(NUM_CHIPS));
  assign w_busy      = (r_state != ST_IDLE);

  // State register; BC1/BDIR are registered from the next state so the PSG
  // lines never glitch on state decoding.
  always_ff @(posedge i_cpu_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      o_bc1   <= 1'b0;
      o_bdir  <= 1'b0;
    end else begin
      r_state <= w_next;
      o_bc1   <= w_bc1;
      o_bdir  <= w_bdir;
      if (w_next != r_state) r_cnt <= 2'd0;
      else if (r_cnt != 2'd3) r_cnt <= r_cnt + 2'd1;
    end
  end

  // Next-state and next-output decode. Chip-select writes never leave IDLE.
  always_comb begin
    w_next = r_state;
    w_bc1  = 1'b0;
    w_bdir = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_startAddr && !w_selWr) w_next = ST_ADDR;
          else if (w_startData)        w_next = ST_DATA;
`ifndef AY_REG_SHADOW_EN
          else if (w_startRead)        w_next = ST_READ;
`endif
        end
      end
      ST_ADDR, ST_DATA: if (r_cnt == PULSE_LAST) w_next = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
      ST_HOLD:          if (r_cnt == HOLD_LAST)  w_next = ST_IDLE;
      ST_READ:          if (r_iorq || r_rd)      w_next = ST_IDLE;
      default:          w_next = ST_IDLE;
    endcase
    case (w_next)
      ST_ADDR: begin w_bc1 = 1'b1; w_bdir = 1'b1; end
      ST_DATA: w_bdir = 1'b1;
      ST_READ: w_bc1  = 1'b1;
      default: ;
    endcase
  end

  // Chip-select latch, its one-cycle IORQGE pulse, and the sticky overrun.
  always_ff @(posedge i_cpu_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_selIdx   <= 3'd0;
      r_selPulse <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      r_selPulse <= w_accept && w_startAddr && w_selWr;
      if (w_accept && w_startAddr && w_selWr && w_selValid) r_selIdx <= w_newIdx;
      if (w_start && w_busy) o_overrun <= 1'b1;
    end
  end

  always_comb begin
    o_ym_sel = '1;
    for (int i = 0; i < NUM_CHIPS; i++) o_ym_sel[i] = (r_selIdx != 3'(i));
  end

  assign o_busy = w_busy;

`ifdef AY_REG_SHADOW_EN
  logic r_shadowRd;

  // Shadow reads keep the sequencer idle but still claim the I/O cycle.
  always_ff @(posedge i_cpu_clock or negedge i_reset) begin
    if (!i_reset)                   r_shadowRd <= 1'b0;
    else if (w_accept && w_startRead) r_shadowRd <= 1'b1;
    else if (r_iorq || r_rd)        r_shadowRd <= 1'b0;
  end

  ay_reg_shadow #(.NUM_CHIPS(NUM_CHIPS)) uShadow (
    .i_cpu_clock (i_cpu_clock),
    .i_reset     (i_reset),
    .i_sel       (r_selIdx),
    .i_idxWe     (w_accept && w_startAddr && !w_selWr),
    .i_dataWe    (w_accept && w_startData),
    .i_d         (r_d),
    .o_q         (o_shadow_q)
  );

  assign o_ioge_c = w_busy || r_selPulse || r_shadowRd;
`else
  assign o_ioge_c = w_busy || r_selPulse;
`endif

endmodule

// File: tb/tb_ay_multi_bus_ctrl.sv
// tb_ay_multi_bus_ctrl: directed vectors for ay_multi_bus_ctrl with
// NUM_CHIPS=2, PULSE_CYCLES=1, HOLD_CYCLES=1.
module tb_ay_multi_bus_ctrl;

  localparam logic [15:0] A_ADDR = 16'hFFFD;
  localparam logic [15:0] A_DATA = 16'hBFFD;
  localparam logic [2:0]  S_IDLE = 3'b111;  // {iorq, rd, wr}
  localparam logic [2:0]  S_WR   = 3'b010;
  localparam logic [2:0]  S_RD   = 3'b001;
  localparam logic [2:0]  S_RW   = 3'b000;
`ifdef AY_REG_SHADOW_EN
  localparam logic [3:0]  RD_OUT = 4'b0001; // {bc1, bdir, busy, ioge}
`else
  localparam logic [3:0]  RD_OUT = 4'b1011;
`endif

  typedef struct {
    logic [15:0] a;
    logic [2:0]  strb;
    logic        m1;
    logic        dos;
    logic [7:0]  d;
    logic [3:0]  outs;
    logic [1:0]  ysel;
    logic        ovr;
  } vec_t;

  logic        clk, rstN;
  logic [15:0] a;
  logic        iorq, rd, wr, m1, dos;
  logic [7:0]  d;
  logic        bc1, bdir, ioge, busy, overrun;
  logic [1:0]  ysel;
`ifdef AY_REG_SHADOW_EN
  logic [7:0]  shadowQ;
`endif
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[$];

  ay_multi_bus_ctrl #(.NUM_CHIPS(2), .PULSE_CYCLES(1), .HOLD_CYCLES(1)) dut (
    .i_cpu_clock (clk),
    .i_reset     (rstN),
    .i_a         (a),
    .i_iorq      (iorq),
    .i_rd        (rd),
    .i_wr        (wr),
    .i_m1        (m1),
    .i_dos       (dos),
    .i_d         (d),
    .o_bc1       (bc1),
    .o_bdir      (bdir),
    .o_ym_sel    (ysel),
    .o_ioge_c    (ioge),
    .o_busy      (busy),
    .o_overrun   (overrun)
`ifdef AY_REG_SHADOW_EN
    ,.o_shadow_q (shadowQ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [15:0] va, input logic [2:0] vs,
                              input logic vm1, input logic vdos, input logic [7:0] vd,
                              input logic [3:0] vo, input logic [1:0] vy, input logic vov);
    vec_t v;
    v.a = va; v.strb = vs; v.m1 = vm1; v.dos = vdos; v.d = vd;
    v.outs = vo; v.ysel = vy; v.ovr = vov;
    return v;
  endfunction

  // Drive one cycle of bus inputs at the falling edge, then step past the
  // next rising edge so outputs can be sampled.
  task automatic applyStimulus(input logic [15:0] va, input logic [2:0] vs,
                               input logic vm1, input logic vdos, input logic [7:0] vd);
    @(negedge clk);
    a = va; {iorq, rd, wr} = vs; m1 = vm1; dos = vdos; d = vd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    applyStimulus(16'h0000, S_IDLE, 1'b1, 1'b1, 8'h00);
  endtask

  initial begin
    // {bc1,bdir,busy,ioge}; ym_sel; overrun -- outputs after that row's edge
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, 4'b0000, 2'b10, 0));
    vecs.push_back(mk(A_ADDR,   S_WR,   1, 1, 8'h07, 4'b0000, 2'b10, 0));
    vecs.push_back(mk(A_ADDR,   S_WR,   1, 1, 8'h07, 4'b1111, 2'b10, 0));
    vecs.push_back(mk(A_ADDR,   S_WR,   1, 1, 8'h07, 4'b0011, 2'b10, 0));
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, 4'b0000, 2'b10, 0));
    vecs.push_back(mk(A_ADDR,   S_WR,   1, 1, 8'hFE, 4'b0000, 2'b10, 0));
    vecs.push_back(mk(A_ADDR,   S_WR,   1, 1, 8'hFE, 4'b0001, 2'b01, 0));
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_DATA,   S_WR,   1, 1, 8'h3F, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_DATA,   S_WR,   1, 1, 8'h3F, 4'b0111, 2'b01, 0));
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, 4'b0011, 2'b01, 0));
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_ADDR,   S_WR,   1, 1, 8'hFD, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_ADDR,   S_WR,   1, 1, 8'hFD, 4'b0001, 2'b01, 0));
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_ADDR,   S_RD,   1, 0, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_ADDR,   S_RD,   1, 0, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_ADDR,   S_RD,   1, 0, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_ADDR,   S_RD,   1, 1, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_ADDR,   S_RD,   1, 1, 8'h00, RD_OUT,  2'b01, 0));
    vecs.push_back(mk(A_ADDR,   S_RD,   1, 1, 8'h00, RD_OUT,  2'b01, 0));
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, RD_OUT,  2'b01, 0));
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_DATA,   S_RD,   1, 1, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_DATA,   S_RD,   1, 1, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_ADDR,   S_RW,   1, 1, 8'h07, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_ADDR,   S_RW,   1, 1, 8'h07, 4'b1111, 2'b01, 0));
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, 4'b0011, 2'b01, 0));
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_ADDR,   S_WR,   0, 1, 8'h07, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(A_ADDR,   S_WR,   0, 1, 8'h07, 4'b0000, 2'b01, 0));
    vecs.push_back(mk(16'h0000, S_IDLE, 1, 1, 8'h00, 4'b0000, 2'b01, 0));

    rstN = 1'b0;
    a = 16'h0000; {iorq, rd, wr} = S_IDLE; m1 = 1'b1; dos = 1'b1; d = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.bc1",  {7'd0, bc1},     8'd0);
    checkOutput("reset.bdir", {7'd0, bdir},    8'd0);
    checkOutput("reset.busy", {7'd0, busy},    8'd0);
    checkOutput("reset.ioge", {7'd0, ioge},    8'd0);
    checkOutput("reset.ysel", {6'd0, ysel},    8'h02);
    checkOutput("reset.ovr",  {7'd0, overrun}, 8'd0);
    @(negedge clk);
    rstN = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].strb, vecs[i].m1, vecs[i].dos, vecs[i].d);
      checkOutput($sformatf("v%0d.bc1", i),  {7'd0, bc1},     {7'd0, vecs[i].outs[3]});
      checkOutput($sformatf("v%0d.bdir", i), {7'd0, bdir},    {7'd0, vecs[i].outs[2]});
      checkOutput($sformatf("v%0d.busy", i), {7'd0, busy},    {7'd0, vecs[i].outs[1]});
      checkOutput($sformatf("v%0d.ioge", i), {7'd0, ioge},    {7'd0, vecs[i].outs[0]});
      checkOutput($sformatf("v%0d.ysel", i), {6'd0, ysel},    {6'd0, vecs[i].ysel});
      checkOutput($sformatf("v%0d.ovr", i),  {7'd0, overrun}, {7'd0, vecs[i].ovr});
    end

    // Second write edge forced while the first access is in HOLD.
    applyStimulus(A_ADDR, S_WR,   1, 1, 8'h07);
    applyStimulus(A_ADDR, S_IDLE, 1, 1, 8'h07);
    checkOutput("ovr.addrPulse", {7'd0, bc1}, 8'd1);
    applyStimulus(A_ADDR, S_WR,   1, 1, 8'h07);
    checkOutput("ovr.holdBusy", {7'd0, busy}, 8'd1);
    checkOutput("ovr.holdBc1",  {7'd0, bc1},  8'd0);
    idle();
    checkOutput("ovr.set",      {7'd0, overrun}, 8'd1);
    checkOutput("ovr.idle",     {7'd0, busy},    8'd0);
    idle();
    checkOutput("ovr.dropBusy", {7'd0, busy}, 8'd0);
    checkOutput("ovr.dropBdir", {7'd0, bdir}, 8'd0);
    applyStimulus(A_ADDR, S_WR, 1, 1, 8'h07);
    applyStimulus(A_ADDR, S_WR, 1, 1, 8'h07);
    checkOutput("ovr.nextWrite", {7'd0, bc1}, 8'd1);
    idle();
    idle();
    checkOutput("ovr.sticky", {7'd0, overrun}, 8'd1);

    // Reset in the middle of an ADDR pulse (chip 1 still selected).
    applyStimulus(A_ADDR, S_WR, 1, 1, 8'h07);
    applyStimulus(A_ADDR, S_WR, 1, 1, 8'h07);
    checkOutput("rst.preBc1", {7'd0, bc1}, 8'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst.bc1",  {7'd0, bc1},     8'd0);
    checkOutput("rst.bdir", {7'd0, bdir},    8'd0);
    checkOutput("rst.busy", {7'd0, busy},    8'd0);
    checkOutput("rst.ysel", {6'd0, ysel},    8'h02);
    checkOutput("rst.ovr",  {7'd0, overrun}, 8'd0);
    @(negedge clk);
    a = 16'h0000; {iorq, rd, wr} = S_IDLE; d = 8'h00;
    @(negedge clk);
    rstN = 1'b1;
    idle();
    checkOutput("rst.after", {7'd0, busy}, 8'd0);

`ifdef AY_REG_SHADOW_EN
    // Chip 1, R7 = 0x3F, then read it back from the shadow.
    applyStimulus(A_ADDR, S_WR, 1, 1, 8'hFE);
    applyStimulus(A_ADDR, S_WR, 1, 1, 8'hFE);
    idle();
    applyStimulus(A_ADDR, S_WR, 1, 1, 8'h07);
    applyStimulus(A_ADDR, S_WR, 1, 1, 8'h07);
    idle();
    idle();
    applyStimulus(A_DATA, S_WR, 1, 1, 8'h3F);
    applyStimulus(A_DATA, S_WR, 1, 1, 8'h3F);
    idle();
    idle();
    applyStimulus(A_ADDR, S_RD, 1, 1, 8'h00);
    applyStimulus(A_ADDR, S_RD, 1, 1, 8'h00);
    checkOutput("shadow.q",    shadowQ,        8'h3F);
    checkOutput("shadow.bc1",  {7'd0, bc1},    8'd0);
    checkOutput("shadow.bdir", {7'd0, bdir},   8'd0);
    checkOutput("shadow.ioge", {7'd0, ioge},   8'd1);
    idle();
    idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
